// File: rtl/filter_sched_pkg.sv
// Shared state encoding, watchdog length and channel-index width for the filter scheduler.
package filter_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DUMP  = 2'd2
  } state_e;

  localparam int TIMEOUT_CYCLES = 256;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/filter_sched_if.sv
// Request/engine bus between the sampling channels, the scheduler and the averaging engine.
interface filter_sched_if #(
  parameter int NUM_CH = 4,
  parameter int DW     = 8
);
  localparam int CW = filter_sched_pkg::ch_w(NUM_CH);

  logic [NUM_CH-1:0]    req;
  logic [NUM_CH*DW-1:0] sample_in;
  logic [NUM_CH-1:0]    grant;
  logic                 eng_valid;
  logic [CW-1:0]        eng_ch;
  logic [DW-1:0]        eng_data;
  logic                 eng_ready;
  logic                 eng_dump;
  logic                 out_strobe;
  logic [CW-1:0]        out_ch;
  logic                 err;

  modport master (
    output req, sample_in, eng_ready,
    input  grant, eng_valid, eng_ch, eng_data, eng_dump, out_strobe, out_ch, err
  );

  modport slave (
    input  req, sample_in, eng_ready,
    output grant, eng_valid, eng_ch, eng_data, eng_dump, out_strobe, out_ch, err
  );

endinterface

// File: rtl/filter_sched_rr_arb.sv
// Combinational round-robin select: first requester at or after ptr_i, wrapping.
module filter_rr_arb #(
  parameter int NUM_CH = 4,
  parameter int CW     = 2
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [CW-1:0]     ptr_i,
  output logic [NUM_CH-1:0] gnt_o,
  output logic [CW-1:0]     idx_o,
  output logic              any_o
);

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!any_o && req_i[(int'(ptr_i) + i) % NUM_CH]) begin
        any_o = 1'b1;
        idx_o = CW'((int'(ptr_i) + i) % NUM_CH);
      end
    end
    if (any_o) gnt_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/filter_sched.sv
// Shares one averaging engine among NUM_CH channels; optional watchdog via FILTER_SCHED_TIMEOUT_EN.
// state | meaning
// IDLE  | arbitrate pending requests;  ISSUE | sample offered, waiting for eng_ready
// DUMP  | one-cycle average dump/strobe after DECIM samples of a channel
module filter_sched
  import filter_sched_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DW     = 8,
  parameter int DECIM  = 64
) (
  input logic           CLK,
  input logic           RST,
  filter_sched_if.slave bus
);

  localparam int         CW       = ch_w(NUM_CH);
  localparam logic [7:0] CNT_LAST = 8'(DECIM - 1);

  state_e            state_q;
  logic [CW-1:0]     ptr_q, ch_q, out_ch_q, ptr_nxt;
  logic [DW-1:0]     data_q;
  logic [NUM_CH-1:0] sel_q, grant_q;
  logic              valid_q, dump_q;
  logic [7:0]        cnt_q [NUM_CH];

  logic [NUM_CH-1:0] arb_gnt;
  logic [CW-1:0]     arb_idx;
  logic              arb_any;

  filter_rr_arb #(.NUM_CH(NUM_CH), .CW(CW)) u_arb (
    .req_i (bus.req),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  assign ptr_nxt = (ch_q == CW'(NUM_CH - 1)) ? '0 : ch_q + CW'(1);

`ifdef FILTER_SCHED_TIMEOUT_EN
  logic [7:0] wdog_q;
  logic       err_q;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      ch_q     <= '0;
      data_q   <= '0;
      sel_q    <= '0;
      grant_q  <= '0;
      valid_q  <= 1'b0;
      dump_q   <= 1'b0;
      out_ch_q <= '0;
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
`ifdef FILTER_SCHED_TIMEOUT_EN
      wdog_q   <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      grant_q <= '0;
      dump_q  <= 1'b0;
`ifdef FILTER_SCHED_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (arb_any) begin
            ch_q    <= arb_idx;
            data_q  <= bus.sample_in[arb_idx*DW +: DW];
            sel_q   <= arb_gnt;
            valid_q <= 1'b1;
            state_q <= ISSUE;
`ifdef FILTER_SCHED_TIMEOUT_EN
            wdog_q  <= '0;
`endif
          end
        end
        ISSUE: begin
          if (bus.eng_ready) begin
            grant_q <= sel_q;
            valid_q <= 1'b0;
            ptr_q   <= ptr_nxt;
            if (cnt_q[ch_q] == CNT_LAST) begin
              cnt_q[ch_q] <= '0;
              dump_q      <= 1'b1;
              out_ch_q    <= ch_q;
              state_q     <= DUMP;
            end else begin
              cnt_q[ch_q] <= cnt_q[ch_q] + 8'd1;
              state_q     <= IDLE;
            end
          end
`ifdef FILTER_SCHED_TIMEOUT_EN
          // Stalled engine: drop the sample without grant and move past the channel.
          else if (wdog_q == 8'(TIMEOUT_CYCLES - 1)) begin
            err_q   <= 1'b1;
            valid_q <= 1'b0;
            ptr_q   <= ptr_nxt;
            state_q <= IDLE;
          end else begin
            wdog_q  <= wdog_q + 8'd1;
          end
`endif
        end
        DUMP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.grant      = grant_q;
  assign bus.eng_valid  = valid_q;
  assign bus.eng_ch     = ch_q;
  assign bus.eng_data   = data_q;
  assign bus.eng_dump   = dump_q;
  assign bus.out_strobe = dump_q;
  assign bus.out_ch     = out_ch_q;
`ifdef FILTER_SCHED_TIMEOUT_EN
  assign bus.err        = err_q;
`else
  assign bus.err        = 1'b0;
`endif

endmodule

// File: tb/tb_filter_sched.sv
// Scoreboard bench for filter_sched (NUM_CH=4, DW=8, DECIM=4); honours FILTER_SCHED_TIMEOUT_EN.
module tb_filter_sched;

  localparam logic [31:0] SAMP_DEF = {8'hD3, 8'hC2, 8'hB1, 8'hA0};

  typedef struct {
    logic [1:0] ch;
    logic [7:0] data;
    logic       dump;
  } exp_t;

  logic CLK = 1'b0;
  logic RST;
  int   vectors = 0;
  int   fails   = 0;
  exp_t exp_q[$];

  always #5 CLK = ~CLK;

  filter_sched_if #(.NUM_CH(4), .DW(8)) bus ();

  filter_sched #(.NUM_CH(4), .DW(8), .DECIM(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake and checks the cycle that follows it.
  logic       prev_hs = 1'b0;
  logic [1:0] prev_ch = '0;
  logic       prev_dump = 1'b0;
  always @(negedge CLK) begin
    exp_t       cur;
    logic [3:0] g;
    if (RST !== 1'b1) begin
      prev_hs = 1'b0;
    end else begin
      if (prev_hs || bus.grant != 0 || bus.eng_dump || bus.out_strobe) begin
        g = prev_hs ? (4'b0001 << prev_ch) : 4'b0000;
        chk("grant_pulse", 32'(bus.grant), 32'(g));
        chk("dump_strobe", {30'd0, bus.eng_dump, bus.out_strobe},
            (prev_hs && prev_dump) ? 32'd3 : 32'd0);
        if (prev_hs) chk("valid_low_after_hs", 32'(bus.eng_valid), 32'd0);
        if (prev_hs && prev_dump) chk("out_ch", 32'(bus.out_ch), 32'(prev_ch));
      end
      prev_hs = 1'b0;
      if (bus.eng_valid && bus.eng_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          fails++;
          $display("FAIL unexpected_handshake: got ch %0d data %0h expected none", bus.eng_ch, bus.eng_data);
        end else begin
          cur = exp_q.pop_front();
          chk("hs_ch", 32'(bus.eng_ch), 32'(cur.ch));
          chk("hs_data", 32'(bus.eng_data), 32'(cur.data));
          prev_hs   = 1'b1;
          prev_ch   = cur.ch;
          prev_dump = cur.dump;
        end
      end
    end
  end

  task automatic push(input logic [1:0] ch, input logic [7:0] data, input logic dump);
    exp_t e;
    e.ch = ch; e.data = data; e.dump = dump;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(posedge CLK); #1;
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    @(negedge CLK);
    while (!bus.eng_valid && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk(name, 32'(bus.eng_valid), 32'd1);
  endtask

  task automatic wait_grants(input int n);
    int got = 0;
    for (int c = 0; c < 200 && got < n; c++) begin
      @(posedge CLK); #1;
      if (bus.grant != 0) got++;
    end
    bus.req = '0;
    chk("grant_count", 32'(got), 32'(n));
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_valid"}, 32'(bus.eng_valid), 32'd0);
    chk({name, "_grant"}, 32'(bus.grant), 32'd0);
    chk({name, "_ch_data"}, {22'd0, bus.eng_ch, bus.eng_data}, 32'd0);
    chk({name, "_misc"}, {27'd0, bus.eng_dump, bus.out_strobe, bus.out_ch, bus.err}, 32'd0);
  endtask

  initial begin
    int gaps[4];
    int got, last, vcnt, err_at;
    logic seen;

    RST = 1'b0;
    bus.req = '0;
    bus.sample_in = SAMP_DEF;
    bus.eng_ready = 1'b1;
    #2 chk_all_zero("reset_state");
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;

    // Single requester ch2: latency, data lane and one-cycle grant.
    push(2'd2, 8'hC2, 1'b0);
    @(posedge CLK); #1 bus.req = 4'b0100;
    @(negedge CLK) chk("latency_before", 32'(bus.eng_valid), 32'd0);
    @(negedge CLK) chk("latency_after", 32'(bus.eng_valid), 32'd1);
    wait_grants(1);

    // All four held from ptr 0: order 0,1,2,3,0,1.
    do_reset();
    push(2'd0, 8'hA0, 1'b0); push(2'd1, 8'hB1, 1'b0); push(2'd2, 8'hC2, 1'b0);
    push(2'd3, 8'hD3, 1'b0); push(2'd0, 8'hA0, 1'b0); push(2'd1, 8'hB1, 1'b0);
    bus.req = 4'b1111;
    wait_grants(6);

    // Decimation by 4 on ch0; new sample after every grant, 3-cycle gap around DUMP.
    do_reset();
    push(2'd0, 8'h01, 1'b0); push(2'd0, 8'h02, 1'b0); push(2'd0, 8'h03, 1'b0);
    push(2'd0, 8'h04, 1'b1); push(2'd0, 8'h05, 1'b0);
    bus.sample_in[7:0] = 8'h01;
    bus.req = 4'b0001;
    got = 0; last = 0;
    for (int i = 0; i < 4; i++) gaps[i] = 0;
    for (int c = 0; c < 100 && got < 5; c++) begin
      @(posedge CLK); #1;
      if (bus.grant != 0) begin
        got++;
        if (got > 1) gaps[got-2] = c - last;
        last = c;
        bus.sample_in[7:0] = 8'(got + 1);
      end
    end
    bus.req = '0;
    chk("decim_grants", 32'(got), 32'd5);
    chk("gap1", 32'(gaps[0]), 32'd2);
    chk("gap2", 32'(gaps[1]), 32'd2);
    chk("gap3", 32'(gaps[2]), 32'd2);
    chk("gap_dump", 32'(gaps[3]), 32'd3);
    bus.sample_in = SAMP_DEF;

    // ch1 offered (ptr=1); req/sample/ready churn while ISSUE must not disturb it.
    push(2'd1, 8'hB1, 1'b0);
    bus.eng_ready = 1'b0;
    @(posedge CLK); #1 bus.req = 4'b0010;
    wait_valid("hold_valid_seen");
    got = 0;
    for (int i = 0; i < 12 && got == 0; i++) begin
      @(posedge CLK); #1;
      if (bus.grant != 0) begin
        got = 1;
        bus.req = '0;
      end else begin
        bus.req = 4'($urandom) | 4'b0010;
        bus.sample_in = $urandom;
        bus.eng_ready = 1'($urandom);
        @(negedge CLK);
        if (bus.eng_valid) chk("hold_ch_data", {22'd0, bus.eng_ch, bus.eng_data}, {22'd0, 2'd1, 8'hB1});
      end
    end
    if (got == 0) begin
      bus.eng_ready = 1'b1;
      wait_grants(1);
    end
    bus.req = '0;
    bus.sample_in = SAMP_DEF;
    @(posedge CLK); #1;

    // Engine stalled for 300 cycles on ch0.
    push(2'd0, 8'hA0, 1'b0);
    bus.eng_ready = 1'b0;
    bus.req = 4'b0001;
    wait_valid("stall_valid_seen");
    vcnt = 0; seen = 1'b0; err_at = 0;
    for (int i = 0; i < 300; i++) begin
      if (i > 0) @(negedge CLK);
      if (bus.eng_valid) vcnt++;
      if (bus.err && !seen) begin
        seen = 1'b1;
        err_at = vcnt;
        chk("timeout_valid_low", 32'(bus.eng_valid), 32'd0);
        chk("timeout_no_grant", 32'(bus.grant), 32'd0);
      end
    end
`ifdef FILTER_SCHED_TIMEOUT_EN
    chk("timeout_err_seen", 32'(seen), 32'd1);
    chk("timeout_at_cycle", 32'(err_at), 32'd256);
`else
    chk("stall_no_err", 32'(seen), 32'd0);
    chk("stall_valid_cycles", 32'(vcnt), 32'd300);
`endif
    @(posedge CLK); #1 bus.eng_ready = 1'b1;
    wait_grants(1);

    // Async reset mid-ISSUE on ch2; afterwards ptr=0 picks ch2 ahead of ch3.
    @(posedge CLK); #1;
    bus.eng_ready = 1'b0;
    bus.req = 4'b0100;
    wait_valid("rst_issue_valid_seen");
    #1 RST = 1'b0;
    #1 chk_all_zero("async_reset");
    push(2'd2, 8'hC2, 1'b0);
    push(2'd3, 8'hD3, 1'b0);
    bus.req = 4'b1100;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;
    bus.eng_ready = 1'b1;
    wait_grants(2);

    repeat (5) @(posedge CLK);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/filter_sched.md
FILTER_SCHED -- requirements
Module: filter_sched

Interface
REQ-001 Parameter NUM_CH, default 4: number of input channels sharing one filter/averaging engine, range 2..8.
REQ-002 Parameter DW, default 8: sample width in bits.
REQ-003 Parameter DECIM, default 64: accepted samples per channel per decimated output, range 1..256.
REQ-004 CLK  input  1  clock; all state changes on rising edge.
REQ-005 RST  input  1  reset, asynchronous, active-low.
REQ-006 req  input  NUM_CH  per-channel sample request; held high until that channel's grant.
REQ-007 sample_in  input  NUM_CH*DW  channel k sample at bits [k*DW +: DW]; valid while req[k] is high.
REQ-008 grant  output  NUM_CH  one-cycle acknowledge to the served channel.
REQ-009 eng_valid  output  1  sample offered to the engine.
REQ-010 eng_ch  output  clog2(NUM_CH)  channel of the offered sample.
REQ-011 eng_data  output  DW  offered sample.
REQ-012 eng_ready  input  1  engine accepts; handshake = eng_valid & eng_ready.
REQ-013 eng_dump  output  1  one-cycle pulse: engine emits the average for eng_ch, then clears that channel's state.
REQ-014 out_strobe  output  1  one-cycle pulse marking a decimated output for out_ch.
REQ-015 out_ch  output  clog2(NUM_CH)  channel of the current out_strobe.
REQ-016 err  output  1  one-cycle engine-timeout pulse (macro-dependent, see Configuration).

Function
REQ-017 FSM states: IDLE, ISSUE, DUMP.
REQ-018 IDLE: no req -> stay; any req -> select the winner round-robin, register its sample and channel, go to ISSUE.
REQ-019 Round-robin: search starts at pointer ptr and wraps; after each handshake ptr = served channel + 1 mod NUM_CH.
REQ-020 Latency: req seen high at edge n -> eng_valid high from edge n+1.
REQ-021 ISSUE: eng_valid=1; eng_ch/eng_data stay constant until handshake, regardless of req changes.
REQ-022 Handshake at edge m: grant[ch] high for cycle m+1 only; eng_valid low in cycle m+1; channel counter cnt[ch] increments.
REQ-023 If cnt[ch] was DECIM-1 at handshake: cnt[ch] wraps to 0 and the FSM goes to DUMP; else it goes to IDLE.
REQ-024 DUMP lasts exactly one cycle: eng_dump=1, out_strobe=1, out_ch=ch; then IDLE.
REQ-025 DECIM=1: every handshake is followed by DUMP.
REQ-026 eng_ready held high: ISSUE lasts one cycle; a single requester is served every 2 cycles (3 when DUMP is inserted).
REQ-027 Channel counters are 8-bit and independent; other channels' counters never change.
REQ-028 A req arriving during ISSUE or DUMP waits and is arbitrated on the next IDLE cycle.

Reset
REQ-029 On RST low, asynchronously: state IDLE, ptr 0, all cnt 0, and all outputs 0 (grant, eng_valid, eng_ch, eng_data, eng_dump, out_strobe, out_ch, err).
REQ-030 Reset during ISSUE drops the pending sample with no grant; the requester keeps req high and is re-served after reset release.

Configuration
REQ-031 Macro FILTER_SCHED_TIMEOUT_EN defined: an 8-bit watchdog counts ISSUE cycles without handshake; at the 256th such cycle, err pulses, the sample is dropped, grant is not asserted, cnt is unchanged, ptr advances past the channel, and the FSM returns to IDLE.
REQ-032 Macro not defined: no watchdog; ISSUE waits indefinitely; err is tied to 0.

Structure
REQ-033 Package filter_sched_pkg holds the state enumeration, the TIMEOUT_CYCLES=256 constant, and the channel-index width function.
REQ-034 Sub-module filter_rr_arb: combinational round-robin select (req, ptr -> one-hot winner, index, any).

Verification
REQ-035 NUM_CH=4, req=0100, eng_ready=1 -> eng_valid next cycle with eng_ch=2 and eng_data=sample_in[23:16]; grant=0100 for one cycle after.
REQ-036 req=1111 held, eng_ready=1 -> service order 0,1,2,3,0,1; each grant is one cycle wide.
REQ-037 DECIM=4, ch0 only -> 4th handshake followed by eng_dump=1, out_strobe=1, out_ch=0; 5th sample starts a new count.
REQ-038 eng_ready=0 for 300 cycles with macro -> err at the 256th ISSUE cycle, no grant, FSM in IDLE; without macro -> eng_valid held for all 300 cycles, err=0.
REQ-039 RST low mid-ISSUE -> all outputs 0 immediately, without waiting for a clock edge; after release the same channel is re-served, with ptr starting at 0.
REQ-040 eng_ready toggling randomly while req changes during ISSUE -> eng_ch/eng_data stay constant until handshake.
